// File: rtl/ikascc_vrc_scci.sv
// SCC-I (SCC+) cartridge mapper: four bank registers plus a mode register that
// turns banks into writable RAM and selects the SCC or SCC+ sound register window.
module ikascc_vrc_scci #(
  parameter int BANKW         = 6,
  parameter int SCCP_EN       = 1,
  parameter int RAMCTRL_ASYNC = 0
) (
  input  logic             i_EMUCLK,
  input  logic             i_RST,
  input  logic             i_MCLK_PCEN_n,
  input  logic             i_CS_n,
  input  logic             i_RD_n,
  input  logic             i_WRRQ,
  input  logic [7:0]       i_DB,
  input  logic [4:0]       i_ABHI,
  input  logic [7:0]       i_ABLO,
  output logic             o_ROMCS_n,
  output logic [BANKW-1:0] o_ROMADDR,
  output logic             o_RAMWE,
  output logic             o_SCCREG_EN,
  output logic             o_SCCPREG_EN,
  output logic             o_SCCPLUS
);

  localparam logic SCCP = (SCCP_EN != 0);

  logic [3:0][7:0] br_q, br_d;
  logic [7:0]      mode_q, mode_d;
  logic            ramwe_q, sccreg_q, sccpreg_q;

  logic [1:0] bank_idx;
  logic [7:0] bank_val;
  logic [3:0] wrable;
  logic       in_rom;
  logic       mode_hit;
  logic       scc_hit;
  logic       sccp_hit;
  logic       win_hit;
  logic       brreg_hit;
  logic [2:0] brreg_off;
  logic [1:0] brreg_idx;
  logic       ram_wr;
  logic       unused_ok;

  always_comb begin
    bank_idx  = {~i_ABHI[3], i_ABHI[2]};
    bank_val  = br_q[bank_idx];
    // Bank 3 has no private enable bit; only the global RAM bit opens it.
    wrable    = {mode_q[4],
                 mode_q[4] | mode_q[2],
                 mode_q[4] | mode_q[1],
                 mode_q[4] | mode_q[0]} & {4{SCCP}};
    in_rom    = i_ABHI[4] ^ i_ABHI[3];
    mode_hit  = SCCP && (i_ABHI == 5'b10111) && (i_ABLO[7:1] == 7'h7F);
    scc_hit   = ~mode_q[5] && (br_q[2][5:0] == 6'h3F) && (i_ABHI == 5'b10011);
    sccp_hit  = SCCP && mode_q[5] && br_q[3][7] && (i_ABHI == 5'b10111);
    win_hit   = scc_hit | sccp_hit;
    brreg_off = i_ABHI[4:2] - 3'd2;
    brreg_idx = brreg_off[1:0];
    brreg_hit = (i_ABHI[1:0] == 2'b10) && (i_ABHI[4:2] >= 3'd2) && (i_ABHI[4:2] <= 3'd5);
    ram_wr    = i_WRRQ && in_rom && wrable[bank_idx] && !mode_hit && !win_hit;

    br_d = br_q;
    if (i_WRRQ && brreg_hit && !wrable[brreg_idx] && !win_hit) begin
      br_d[brreg_idx] = i_DB;
    end

    mode_d = mode_q;
    if (i_WRRQ && mode_hit) begin
      mode_d = i_DB;
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      br_q      <= {8'h03, 8'h02, 8'h01, 8'h00};
      mode_q    <= 8'h00;
      ramwe_q   <= 1'b0;
      sccreg_q  <= 1'b0;
      sccpreg_q <= 1'b0;
    end else if (!i_MCLK_PCEN_n) begin
      br_q      <= br_d;
      mode_q    <= mode_d;
      ramwe_q   <= ram_wr;
      sccreg_q  <= scc_hit;
      sccpreg_q <= sccp_hit;
    end
  end

  assign o_ROMCS_n    = i_CS_n | i_RD_n;
  assign o_ROMADDR    = bank_val[BANKW-1:0];
  assign o_RAMWE      = ramwe_q;
  assign o_SCCREG_EN  = (RAMCTRL_ASYNC != 0) ? scc_hit  : sccreg_q;
  assign o_SCCPREG_EN = (RAMCTRL_ASYNC != 0) ? sccp_hit : sccpreg_q;
  assign o_SCCPLUS    = mode_q[5];

  // Bits that carry no meaning for this mapper (A0, spare mode bits, bank bits above BANKW).
  assign unused_ok = ^{i_ABLO[0], bank_val, mode_q};

endmodule
